// File: rtl/cycle_count_display.sv
// Captures a 32-bit cycle count on the rising edge of done_in and shows it in decimal on six 7-segment digits.
// Define CYCLE_DISP_LZB_EN to blank leading zero digits (hex0 always shows its numeral).
module cycle_count_display (
    input  logic        clk,
    input  logic        rst,
    input  logic        done_in,
    input  logic [31:0] total_cycles_in,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic        busy,
    output logic        valid
);

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t      state, state_nxt;
    logic        done_q;
    logic        trigger;
    logic        ovf;
    logic [4:0]  iter_cnt;
    logic [19:0] bin;
    logic [23:0] bcd;
    logic [23:0] bcd_adj;
    logic [6:0]  hex_q   [6];
    logic [6:0]  seg_nxt [6];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign trigger = done_in & ~done_q & (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = CONVERT;
            CONVERT: if (iter_cnt == 5'd19) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble correction: any nibble >= 5 would carry past 9 after the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
`ifdef CYCLE_DISP_LZB_EN
        logic leading;
        leading = 1'b1;
`endif
        for (int i = 5; i >= 0; i--) begin
            seg_nxt[i] = seg7(bcd[4*i +: 4]);
`ifdef CYCLE_DISP_LZB_EN
            if (leading && (bcd[4*i +: 4] == 4'd0) && (i != 0)) seg_nxt[i] = 7'h7F;
            else leading = 1'b0;
`endif
            if (ovf) seg_nxt[i] = 7'h3F;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q   <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            iter_cnt <= 5'd0;
            bin      <= 20'd0;
            bcd      <= 24'd0;
            for (int i = 0; i < 6; i++) hex_q[i] <= 7'h7F;
        end else begin
            done_q <= done_in;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        bin      <= total_cycles_in[19:0];
                        bcd      <= 24'd0;
                        ovf      <= (total_cycles_in > 32'd999999);
                        busy     <= 1'b1;
                        valid    <= 1'b0;
                        iter_cnt <= 5'd0;
                    end
                end
                CONVERT: begin
                    {bcd, bin} <= {bcd_adj[22:0], bin, 1'b0};
                    iter_cnt   <= iter_cnt + 5'd1;
                end
                LOAD: begin
                    for (int i = 0; i < 6; i++) hex_q[i] <= seg_nxt[i];
                    valid <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_cycle_count_display.sv
// Bench for cycle_count_display: decimal reference model, expected-display queue, 21-clock latency check.
module tb_cycle_count_display;

    logic        clk;
    logic        rst;
    logic        done_in;
    logic [31:0] total_cycles_in;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        busy;
    logic        valid;

    logic [47:0] exp_q[$];
    logic [47:0] last_exp;
    logic [47:0] hex_bus;
    int          checks;
    int          errors;
    int          cyc;
    int          cap_cyc;
    int          out_cnt;
    logic        prev_busy;
    logic        prev_valid;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    cycle_count_display dut (
        .clk             (clk),
        .rst             (rst),
        .done_in         (done_in),
        .total_cycles_in (total_cycles_in),
        .hex0            (hex0),
        .hex1            (hex1),
        .hex2            (hex2),
        .hex3            (hex3),
        .hex4            (hex4),
        .hex5            (hex5),
        .busy            (busy),
        .valid           (valid)
    );

    assign hex_bus = {6'd0, hex5, hex4, hex3, hex2, hex1, hex0};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [47:0] model(input logic [31:0] v);
        logic [47:0] r;
        logic [3:0]  dg [6];
        int unsigned x;
        logic        lead;
        r    = '0;
        x    = v;
        lead = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dg[i] = 4'(x % 10);
            x     = x / 10;
        end
        for (int i = 5; i >= 0; i--) begin
            if (v > 32'd999999) begin
                r[7*i +: 7] = 7'h3F;
            end else begin
                r[7*i +: 7] = seg_tab[dg[i]];
`ifdef CYCLE_DISP_LZB_EN
                if (lead && dg[i] == 4'd0 && i != 0) r[7*i +: 7] = 7'h7F;
                else lead = 1'b0;
`endif
            end
        end
        return r;
    endfunction

    // scoreboard: a capture is marked by busy rising, a result by valid rising
    always @(negedge clk) begin
        if (rst) begin
            prev_busy  <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            if (busy && !prev_busy) cap_cyc <= cyc;
            if (valid && !prev_valid) begin
                out_cnt <= out_cnt + 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 48'd1, 48'd0);
                end else begin
                    check("display", hex_bus, exp_q.pop_front());
                    check("latency", 48'(cyc - cap_cyc), 48'd21);
                    check("busy_at_load", {47'd0, busy}, 48'd0);
                end
            end
            prev_busy  <= busy;
            prev_valid <= valid;
        end
    end

    // driver tasks
    task automatic wait_out(input int start);
        for (int i = 0; i < 40 && out_cnt == start; i++) @(posedge clk);
        check("result_seen", {47'd0, out_cnt != start}, 48'd1);
    endtask

    task automatic convert(input logic [31:0] v);
        int start;
        @(negedge clk);
        start           = out_cnt;
        total_cycles_in = v;
        done_in         = 1'b1;
        exp_q.push_back(model(v));
        repeat (5) @(negedge clk);
        check("hold_while_busy", hex_bus, last_exp);
        check("busy_mid", {47'd0, busy}, 48'd1);
        wait_out(start);
        last_exp = model(v);
        @(negedge clk);
        done_in = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int start;
        checks          = 0;
        errors          = 0;
        out_cnt         = 0;
        cap_cyc         = 0;
        prev_busy       = 1'b0;
        prev_valid      = 1'b0;
        rst             = 1'b1;
        done_in         = 1'b0;
        total_cycles_in = 32'd0;
        last_exp        = {6'd0, {6{7'h7F}}};
        repeat (3) @(negedge clk);
        check("reset_hex", hex_bus, {6'd0, {6{7'h7F}}});
        check("reset_busy", {47'd0, busy}, 48'd0);
        check("reset_valid", {47'd0, valid}, 48'd0);
        rst = 1'b0;
        @(negedge clk);

        convert(32'd57612);
        convert(32'd0);
        convert(32'd999999);
        convert(32'd1000000);
        convert(32'hFFFF_FFFF);
        convert(32'd7);
        for (int i = 0; i < 4; i++) convert(32'($urandom_range(0, 1100000)));

        repeat (5) @(negedge clk);
        check("valid_sticky", {47'd0, valid}, 48'd1);
        check("display_sticky", hex_bus, last_exp);

        // done_in held high: one conversion only, then low for one clock and high again
        @(negedge clk);
        start           = out_cnt;
        total_cycles_in = 32'd424242;
        done_in         = 1'b1;
        exp_q.push_back(model(32'd424242));
        repeat (100) @(negedge clk);
        check("single_conversion", 48'(out_cnt - start), 48'd1);
        done_in = 1'b0;
        @(negedge clk);
        start           = out_cnt;
        done_in         = 1'b1;
        total_cycles_in = 32'd123;
        exp_q.push_back(model(32'd123));
        wait_out(start);
        last_exp = model(32'd123);
        @(negedge clk);
        done_in = 1'b0;
        @(negedge clk);

        // re-pulse during CONVERT is lost
        start           = out_cnt;
        total_cycles_in = 32'd31337;
        done_in         = 1'b1;
        exp_q.push_back(model(32'd31337));
        repeat (5) @(negedge clk);
        done_in = 1'b0;
        @(negedge clk);
        total_cycles_in = 32'd88;
        done_in         = 1'b1;
        wait_out(start);
        repeat (30) @(negedge clk);
        check("pulse_ignored", 48'(out_cnt - start), 48'd1);
        check("queue_empty", 48'(exp_q.size()), 48'd0);
        done_in = 1'b0;
        @(negedge clk);

        // reset mid-conversion aborts; done_in still high recaptures on release
        total_cycles_in = 32'd4242;
        done_in         = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_hex", hex_bus, {6'd0, {6{7'h7F}}});
        check("abort_busy", {47'd0, busy}, 48'd0);
        check("abort_valid", {47'd0, valid}, 48'd0);
        @(negedge clk);
        start           = out_cnt;
        total_cycles_in = 32'd654321;
        exp_q.push_back(model(32'd654321));
        rst = 1'b0;
        @(negedge clk);
        check("recapture_busy", {47'd0, busy}, 48'd1);
        wait_out(start);
        @(negedge clk);
        done_in = 1'b0;
        repeat (3) @(negedge clk);
        check("final_queue_empty", 48'(exp_q.size()), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
